// File: rtl/uarc_char_bridge.sv
// Byte-stream bridge between a core's UARC buses and byte-wide host ports.
// Each channel owns an RX queue (host -> core) and a TX queue (core -> host).
module uarc_char_bridge #(
  parameter int WORD_MAG = 5,
  parameter int CHANNELS = 1,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter logic [(1<<WORD_MAG)-1:0] EOF_WORD = '1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  output logic [CHANNELS-1:0]                    receiver_sends,
  input  logic [CHANNELS-1:0]                    receiver_send_acks,
  output logic [CHANNELS*(1<<WORD_MAG)-1:0]      receiver_datas,
  input  logic                                   global_send,
  input  logic [(1<<WORD_MAG)-1:0]               global_data,
  input  logic [CHANNELS-1:0]                    sender_enables,
  output logic [CHANNELS-1:0]                    sender_send_acks,
  input  logic [CHANNELS-1:0]                    host_rx_valid,
  input  logic [CHANNELS-1:0]                    host_rx_eof,
  input  logic [CHANNELS*8-1:0]                  host_rx_data,
  output logic [CHANNELS-1:0]                    host_rx_ready,
  output logic [CHANNELS-1:0]                    host_tx_valid,
  output logic [CHANNELS*8-1:0]                  host_tx_data,
  input  logic [CHANNELS-1:0]                    host_tx_ready,
  output logic [CHANNELS*(FIFO_ADDR_WIDTH+1)-1:0] rx_level,
  output logic [CHANNELS*(FIFO_ADDR_WIDTH+1)-1:0] tx_level
);

  localparam int WORD_WIDTH = 1 << WORD_MAG;
  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int LW = FIFO_ADDR_WIDTH + 1;
  localparam logic [FIFO_ADDR_WIDTH:0] FULL = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
  localparam logic [FIFO_ADDR_WIDTH:0] EMPTY = '0;
  localparam logic [FIFO_ADDR_WIDTH:0] LVL_ONE = {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE = {{(FIFO_ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Only the low byte of a core word travels to the host.
  if (WORD_WIDTH > 8) begin : g_unused
    logic unused_upper_bits;
    assign unused_upper_bits = ^global_data[WORD_WIDTH-1:8];
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [8:0]                 rx_mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] rx_wr, rx_rd;
    logic [FIFO_ADDR_WIDTH:0]   rx_cnt;
    logic                       rx_push, rx_pop;
    logic [8:0]                 rx_head;

    logic [7:0]                 tx_mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] tx_wr, tx_rd;
    logic [FIFO_ADDR_WIDTH:0]   tx_cnt;
    logic                       tx_push, tx_pop;

    // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
    assign rx_push = host_rx_valid[c] && (rx_cnt != FULL);
    assign rx_pop  = receiver_send_acks[c] && (rx_cnt != EMPTY);
    assign rx_head = rx_mem[rx_rd];

    assign host_rx_ready[c]  = (rx_cnt != FULL);
    assign receiver_sends[c] = (rx_cnt != EMPTY);
    assign receiver_datas[c*WORD_WIDTH +: WORD_WIDTH] =
      rx_head[8] ? EOF_WORD : {{(WORD_WIDTH-8){1'b0}}, rx_head[7:0]};
    assign rx_level[c*LW +: LW] = rx_cnt;

    always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr] <= {host_rx_eof[c], host_rx_data[c*8 +: 8]};
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rx_wr  <= '0;
        rx_rd  <= '0;
        rx_cnt <= '0;
      end else begin
        if (rx_push) rx_wr <= rx_wr + PTR_ONE;
        if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
        case ({rx_push, rx_pop})
          2'b10:   rx_cnt <= rx_cnt + LVL_ONE;
          2'b01:   rx_cnt <= rx_cnt - LVL_ONE;
          default: rx_cnt <= rx_cnt;
        endcase
      end
    end

    // The send ack depends only on the core bus and registered TX occupancy.
    assign tx_push = global_send && sender_enables[c] && (tx_cnt != FULL);
    assign tx_pop  = host_tx_ready[c] && (tx_cnt != EMPTY);

    assign sender_send_acks[c]  = tx_push;
    assign host_tx_valid[c]     = (tx_cnt != EMPTY);
    assign host_tx_data[c*8 +: 8] = tx_mem[tx_rd];
    assign tx_level[c*LW +: LW] = tx_cnt;

    always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr] <= global_data[7:0];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        tx_wr  <= '0;
        tx_rd  <= '0;
        tx_cnt <= '0;
      end else begin
        if (tx_push) tx_wr <= tx_wr + PTR_ONE;
        if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
        case ({tx_push, tx_pop})
          2'b10:   tx_cnt <= tx_cnt + LVL_ONE;
          2'b01:   tx_cnt <= tx_cnt - LVL_ONE;
          default: tx_cnt <= tx_cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uarc_char_bridge.sv
// Directed bench for uarc_char_bridge with a scoreboard of expected RX words and TX bytes.
module tb_uarc_char_bridge;

  localparam int CH = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset;
  logic [CH-1:0] receiver_sends;
  logic [CH-1:0] receiver_send_acks;
  logic [CH*32-1:0] receiver_datas;
  logic          global_send;
  logic [31:0]   global_data;
  logic [CH-1:0] sender_enables;
  logic [CH-1:0] sender_send_acks;
  logic [CH-1:0] host_rx_valid;
  logic [CH-1:0] host_rx_eof;
  logic [CH*8-1:0] host_rx_data;
  logic [CH-1:0] host_rx_ready;
  logic [CH-1:0] host_tx_valid;
  logic [CH*8-1:0] host_tx_data;
  logic [CH-1:0] host_tx_ready;
  logic [CH*5-1:0] rx_level;
  logic [CH*5-1:0] tx_level;

  int checks = 0;
  int failures = 0;
  int ack_seen = 0;
  int rx_lvl = 0;
  int tx_lvl [CH];
  logic [31:0] rx_q [$];
  logic [7:0]  tx_q0 [$];
  logic [7:0]  tx_q2 [$];

  uarc_char_bridge #(
    .WORD_MAG(5),
    .CHANNELS(CH),
    .FIFO_ADDR_WIDTH(4),
    .EOF_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .receiver_sends(receiver_sends),
    .receiver_send_acks(receiver_send_acks),
    .receiver_datas(receiver_datas),
    .global_send(global_send),
    .global_data(global_data),
    .sender_enables(sender_enables),
    .sender_send_acks(sender_send_acks),
    .host_rx_valid(host_rx_valid),
    .host_rx_eof(host_rx_eof),
    .host_rx_data(host_rx_data),
    .host_rx_ready(host_rx_ready),
    .host_tx_valid(host_tx_valid),
    .host_tx_data(host_tx_data),
    .host_tx_ready(host_tx_ready),
    .rx_level(rx_level),
    .tx_level(tx_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock of channel-0 RX traffic plus core sends; model tracks levels and scoreboards data.
  task automatic applyStimulus(input logic rxv, input logic rxe, input logic [7:0] rxd, input logic rxa,
                               input logic gs, input logic [31:0] gd, input logic [3:0] en,
                               input logic [3:0] txr);
    logic [3:0]  exp_ack;
    logic [3:0]  tx_pop;
    logic [3:0]  exp_valid;
    logic        rx_push;
    logic        rx_pop;
    logic [31:0] exp_word;
    logic [7:0]  exp_byte;
    host_rx_valid      = {3'b000, rxv};
    host_rx_eof        = {3'b000, rxe};
    host_rx_data       = {24'h0, rxd};
    receiver_send_acks = {3'b000, rxa};
    global_send        = gs;
    global_data        = gd;
    sender_enables     = en;
    host_tx_ready      = txr;
    #1;
    checkOutput("rx_ready", 32'(host_rx_ready[0]), 32'(rx_lvl != DEPTH));
    for (int c = 0; c < CH; c++) exp_ack[c] = gs && en[c] && (tx_lvl[c] != DEPTH);
    checkOutput("tx_ack", 32'(sender_send_acks), 32'(exp_ack));
    if (sender_send_acks[0]) ack_seen++;
    rx_pop = rxa && (rx_lvl != 0);
    if (rx_pop) begin
      exp_word = rx_q.pop_front();
      checkOutput("rx_data", receiver_datas[31:0], exp_word);
    end
    rx_push = rxv && (rx_lvl != DEPTH);
    if (rx_push) rx_q.push_back(rxe ? 32'hFFFF_FFFF : {24'h0, rxd});
    for (int c = 0; c < CH; c++) tx_pop[c] = txr[c] && (tx_lvl[c] != 0);
    if (tx_pop[0]) begin
      exp_byte = tx_q0.pop_front();
      checkOutput("tx_data0", 32'(host_tx_data[7:0]), 32'(exp_byte));
    end
    if (tx_pop[2]) begin
      exp_byte = tx_q2.pop_front();
      checkOutput("tx_data2", 32'(host_tx_data[23:16]), 32'(exp_byte));
    end
    if (exp_ack[0]) tx_q0.push_back(gd[7:0]);
    if (exp_ack[2]) tx_q2.push_back(gd[7:0]);
    @(posedge clk);
    #1;
    rx_lvl = rx_lvl + int'(rx_push) - int'(rx_pop);
    for (int c = 0; c < CH; c++) begin
      tx_lvl[c] = tx_lvl[c] + int'(exp_ack[c]) - int'(tx_pop[c]);
      exp_valid[c] = (tx_lvl[c] != 0);
    end
    checkOutput("rx_level0", 32'(rx_level[4:0]), 32'(rx_lvl));
    checkOutput("rx_send0", 32'(receiver_sends[0]), 32'(rx_lvl != 0));
    checkOutput("tx_level0", 32'(tx_level[4:0]), 32'(tx_lvl[0]));
    checkOutput("tx_level2", 32'(tx_level[14:10]), 32'(tx_lvl[2]));
    checkOutput("tx_valid", 32'(host_tx_valid), 32'(exp_valid));
  endtask

  task automatic doReset();
    host_rx_valid = '0; host_rx_eof = '0; host_rx_data = '0; receiver_send_acks = '0;
    global_send = 1'b0; global_data = '0; sender_enables = '0; host_tx_ready = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_rx_send", 32'(receiver_sends), 32'h0);
    checkOutput("rst_tx_valid", 32'(host_tx_valid), 32'h0);
    checkOutput("rst_rx_ready", 32'(host_rx_ready), 32'hF);
    checkOutput("rst_rx_level", 32'(rx_level), 32'h0);
    checkOutput("rst_tx_level", 32'(tx_level), 32'h0);
    checkOutput("rst_tx_ack", 32'(sender_send_acks), 32'h0);
    reset = 1'b0;
    rx_lvl = 0;
    for (int c = 0; c < CH; c++) tx_lvl[c] = 0;
    rx_q.delete();
    tx_q0.delete();
    tx_q2.delete();
  endtask

  initial begin
    reset = 1'b1;
    doReset();

    // 'H','i' back to back with the core acking every cycle
    applyStimulus(1, 0, 8'h48, 0, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(1, 0, 8'h69, 1, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 4'b0000, 4'b0000);

    // RX fill to full, reject a 17th, then pop while a push is held off
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 8'(8'h30 + i), 0, 0, 0, 4'b0000, 4'b0000);
    checkOutput("rx_full_level", 32'(rx_level[4:0]), 32'd16);
    applyStimulus(1, 0, 8'hEE, 0, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(1, 0, 8'hEF, 1, 0, 0, 4'b0000, 4'b0000);
    checkOutput("rx_after_pop_ready", 32'(host_rx_ready[0]), 32'h1);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(0, 0, 8'h00, 1, 0, 0, 4'b0000, 4'b0000);

    // Byte followed by an end-of-file marker
    applyStimulus(1, 0, 8'h41, 0, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(1, 1, 8'h99, 1, 0, 0, 4'b0000, 4'b0000);
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 4'b0000, 4'b0000);

    // TX backpressure: twenty sends, sixteen accepted, then drain
    ack_seen = 0;
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 8'h00, 0, 1, 32'h1234_5678, 4'b0001, 4'b0000);
    checkOutput("tx_ack_count", 32'(ack_seen), 32'd16);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 8'h00, 0, 0, 0, 4'b0000, 4'b0001);

    // Multicast with channel 2 full: only channel 0 takes the byte
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 8'h00, 0, 1, 32'(32'hA0 + i), 4'b0100, 4'b0000);
    applyStimulus(0, 0, 8'h00, 0, 1, 32'hCAFE_BA5E, 4'b0101, 4'b0000);
    checkOutput("mcast_lvl2", 32'(tx_level[14:10]), 32'd16);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 8'h00, 0, 0, 0, 4'b0000, 4'b0101);

    // Half-full queues discarded by reset, then wrapping traffic
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 8'(8'h10 + i), 0, 1, 32'(32'h50 + i), 4'b0001, 4'b0000);
    doReset();
    for (int i = 0; i < 24; i++)
      applyStimulus(i < 20, 0, 8'(8'hC0 + i), i > 0, i < 20, $urandom, 4'b0001, {3'b000, i > 0});
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 1, 0, 0, 4'b0000, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
